// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: the forward-select
// encodings and the register-index width derivation.
package fwd_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    function automatic int fwd_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/forward_hazard_ctrl_if.sv
// Pipeline-side bundle of the forwarding/hazard controller: the master is the
// pipeline driving register indices, the slave is the controller.
interface forward_hazard_ctrl_if import fwd_pkg::*; #(
    parameter int RP      = 2,
    parameter int NREG    = 32,
    parameter int MAX_OUT = 4
);
    localparam int AW = fwd_aw(NREG);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic              id_valid;
    logic [RP*AW-1:0]  id_rs;
    logic [RP-1:0]     id_rs_used;
    logic [AW-1:0]     id_rd;
    logic              id_regwrite;
    logic              id_long;
    logic [RP*AW-1:0]  ex_rs;
    logic              ex_memread;
    logic [AW-1:0]     ex_rd;
    logic [AW-1:0]     ex_mem_rd;
    logic [AW-1:0]     mem_wb_rd;
    logic              ex_mem_regwrite;
    logic              mem_wb_regwrite;
    logic              lu_valid;
    logic [AW-1:0]     lu_rd;
    logic [RP*2-1:0]   ex_fwd_sel;
    logic [RP-1:0]     id_lu_fwd;
    logic              stall;
    logic [OW-1:0]     outstanding;
    logic              lu_err;
    logic [31:0]       load_use_cnt;
    logic [31:0]       busy_stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_long,
               ex_rs, ex_memread, ex_rd, ex_mem_rd, mem_wb_rd,
               ex_mem_regwrite, mem_wb_regwrite, lu_valid, lu_rd,
        input  ex_fwd_sel, id_lu_fwd, stall, outstanding, lu_err,
               load_use_cnt, busy_stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_long,
               ex_rs, ex_memread, ex_rd, ex_mem_rd, mem_wb_rd,
               ex_mem_regwrite, mem_wb_regwrite, lu_valid, lu_rd,
        output ex_fwd_sel, id_lu_fwd, stall, outstanding, lu_err,
               load_use_cnt, busy_stall_cnt
    );

endinterface

// File: rtl/forward_hazard_ctrl_port_sel.sv
// Per-operand EX forward select: the younger EX/MEM result wins over MEM/WB.
module fwd_port_sel import fwd_pkg::*; #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] ex_mem_rd,
    input  logic          ex_mem_regwrite,
    input  logic [AW-1:0] mem_wb_rd,
    input  logic          mem_wb_regwrite,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == rs)
            sel = FWD_MEM;
        else if (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == rs)
            sel = FWD_WB;
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard controller with a long-latency-unit scoreboard.
// Optional stall performance counters are built when FWD_PERF_CNT_EN is defined.
module forward_hazard_ctrl import fwd_pkg::*; #(
    parameter int RP      = 2,
    parameter int NREG    = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    forward_hazard_ctrl_if.slave  bus
);

    localparam int AW = fwd_aw(NREG);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] OUT_FULL = OW'(MAX_OUT);

    logic [NREG-1:0] busy;
    logic [OW-1:0]   outstanding_q;
    logic            lu_err_q;
    logic [RP*2-1:0] fwd_sel;
    logic [RP-1:0]   lu_fwd;
    logic [RP-1:0]   load_use;
    logic [RP-1:0]   raw_busy;
    logic            waw;
    logic            structural;
    logic            stall_c;
    logic            issue_long;
    logic            lu_ok;
    logic            lu_bad;

    for (genvar i = 0; i < RP; i++) begin : g_op
        logic [AW-1:0] id_src;
        assign id_src = bus.id_rs[i*AW +: AW];

        fwd_port_sel #(.AW(AW)) u_sel (
            .rs              (bus.ex_rs[i*AW +: AW]),
            .ex_mem_rd       (bus.ex_mem_rd),
            .ex_mem_regwrite (bus.ex_mem_regwrite),
            .mem_wb_rd       (bus.mem_wb_rd),
            .mem_wb_regwrite (bus.mem_wb_regwrite),
            .sel             (fwd_sel[i*2 +: 2])
        );

        assign lu_fwd[i]   = bus.lu_valid && bus.lu_rd != '0 && bus.lu_rd == id_src
                             && bus.id_rs_used[i];
        assign load_use[i] = bus.ex_memread && bus.ex_rd != '0 && bus.ex_rd == id_src
                             && bus.id_rs_used[i];
        // A result arriving from the LU this cycle is bypassed, so it no longer blocks.
        assign raw_busy[i] = busy[id_src] && bus.id_rs_used[i] && !lu_fwd[i];
    end

    assign waw        = bus.id_regwrite && bus.id_rd != '0 && busy[bus.id_rd]
                        && !(bus.lu_valid && bus.lu_rd == bus.id_rd);
    assign structural = bus.id_long && outstanding_q == OUT_FULL && !bus.lu_valid;
    assign stall_c    = bus.id_valid && (|load_use || |raw_busy || waw || structural);
    assign issue_long = bus.id_valid && !stall_c && bus.id_regwrite && bus.id_long
                        && bus.id_rd != '0;
    assign lu_ok      = bus.lu_valid && bus.lu_rd != '0 && busy[bus.lu_rd]
                        && outstanding_q != '0;
    assign lu_bad     = bus.lu_valid && !lu_ok;

    // The set is written last so a same-cycle set and clear leaves the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (lu_ok)
                busy[bus.lu_rd] <= 1'b0;
            if (issue_long)
                busy[bus.id_rd] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            lu_err_q      <= 1'b0;
        end else begin
            if (issue_long && !lu_ok && outstanding_q != OUT_FULL)
                outstanding_q <= outstanding_q + 1'b1;
            else if (lu_ok && !issue_long)
                outstanding_q <= outstanding_q - 1'b1;
            if (lu_bad)
                lu_err_q <= 1'b1;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] load_use_q;
    logic [31:0] busy_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_use_q   <= '0;
            busy_stall_q <= '0;
        end else begin
            if (bus.id_valid && |load_use && load_use_q != 32'hFFFF_FFFF)
                load_use_q <= load_use_q + 32'd1;
            if ((|raw_busy || waw) && busy_stall_q != 32'hFFFF_FFFF)
                busy_stall_q <= busy_stall_q + 32'd1;
        end
    end

    assign bus.load_use_cnt   = load_use_q;
    assign bus.busy_stall_cnt = busy_stall_q;
`else
    assign bus.load_use_cnt   = '0;
    assign bus.busy_stall_cnt = '0;
`endif

    assign bus.ex_fwd_sel  = fwd_sel;
    assign bus.id_lu_fwd   = lu_fwd;
    assign bus.stall       = stall_c;
    assign bus.outstanding = outstanding_q;
    assign bus.lu_err      = lu_err_q;

endmodule
